// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine feeding hilo_reg; one bit per CALC cycle.
// Optional abort input enabled by defining MULDIV_ABORT_EN.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       md_op,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
`ifdef MULDIV_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             W_HILO,
    output logic [WIDTH-1:0] Write_HI,
    output logic [WIDTH-1:0] Write_LO
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             state_q, state_d;
    logic               accept_q, accept_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               load_res;
    logic [WIDTH-1:0]   res_hi_q, res_lo_q;

    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q, m_q, m_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, fixed;
    logic               neg_x_q, neg_a_q, div0_q;

    logic               abort_w;
    logic               is_signed, is_div, sa, sb;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     msum, dshift, ddiff;

`ifdef MULDIV_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    // Signed results are formed from magnitudes; div-by-zero overrides the array result.
    function automatic logic [2*WIDTH-1:0] fix_result(
        input logic [2*WIDTH-1:0] acc,
        input logic               div,
        input logic               neg_x,
        input logic               neg_a,
        input logic               div0,
        input logic [WIDTH-1:0]   a_raw
    );
        logic [WIDTH-1:0] hi, lo;
        hi = acc[2*WIDTH-1:WIDTH];
        lo = acc[WIDTH-1:0];
        if (div0)
            fix_result = {a_raw, {WIDTH{1'b1}}};
        else if (!div)
            fix_result = neg_x ? (~acc + 1'b1) : acc;
        else
            fix_result = {neg_a ? (~hi + 1'b1) : hi, neg_x ? (~lo + 1'b1) : lo};
    endfunction

    assign is_signed = ~op_q[0];
    assign is_div    = op_q[1];
    assign sa        = is_signed & a_q[WIDTH-1];
    assign sb        = is_signed & b_q[WIDTH-1];
    assign mag_a     = sa ? (~a_q + 1'b1) : a_q;
    assign mag_b     = sb ? (~b_q + 1'b1) : b_q;

    always_comb begin
        state_d  = state_q;
        accept_d = 1'b0;
        cnt_d    = cnt_q;
        load_res = 1'b0;
        case (state_q)
            IDLE: begin
                // An accepted request spends one cycle forming operand magnitudes.
                if (accept_q) begin
                    state_d = CALC;
                    cnt_d   = '0;
                end else if (start) begin
                    accept_d = 1'b1;
                end
            end
            CALC: begin
                if (abort_w) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST)
                        state_d = FIX;
                end
            end
            FIX: begin
                if (abort_w) begin
                    state_d = IDLE;
                end else begin
                    state_d  = DONE;
                    load_res = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        msum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, acc_q[0] ? m_q : {WIDTH{1'b0}}};
        dshift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        ddiff  = dshift - {1'b0, m_q};
        acc_d  = acc_q;
        m_d    = m_q;
        if (accept_q) begin
            acc_d = {{WIDTH{1'b0}}, is_div ? mag_a : mag_b};
            m_d   = is_div ? mag_b : mag_a;
        end else if (state_q == CALC) begin
            if (is_div)
                acc_d = {ddiff[WIDTH] ? dshift[WIDTH-1:0] : ddiff[WIDTH-1:0],
                         acc_q[WIDTH-2:0], ~ddiff[WIDTH]};
            else
                acc_d = {msum, acc_q[WIDTH-1:1]};
        end
    end

    assign fixed = fix_result(acc_q, is_div, neg_x_q, neg_a_q, div0_q, a_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            accept_q <= 1'b0;
            cnt_q    <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
        end else begin
            state_q  <= state_d;
            accept_q <= accept_d;
            cnt_q    <= cnt_d;
            if (load_res) begin
                res_hi_q <= fixed[2*WIDTH-1:WIDTH];
                res_lo_q <= fixed[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept_d) begin
            op_q <= md_op;
            a_q  <= SrcA;
            b_q  <= SrcB;
        end
        if (accept_q) begin
            neg_x_q <= sa ^ sb;
            neg_a_q <= sa;
            div0_q  <= is_div && (b_q == '0);
        end
        acc_q <= acc_d;
        m_q   <= m_d;
    end

    assign busy     = accept_q || (state_q != IDLE);
    assign W_HILO   = (state_q == DONE);
    assign Write_HI = res_hi_q;
    assign Write_LO = res_lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO queued at issue, popped on W_HILO.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk, rst, start;
    logic [1:0]   md_op;
    logic [W-1:0] SrcA, SrcB;
    logic         busy, W_HILO;
    logic [W-1:0] Write_HI, Write_LO;
`ifdef MULDIV_ABORT_EN
    logic         abort;
`endif

    int total = 0;
    int bad   = 0;
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] last_exp;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .md_op    (md_op),
        .SrcA     (SrcA),
        .SrcB     (SrcB),
`ifdef MULDIV_ABORT_EN
        .abort    (abort),
`endif
        .busy     (busy),
        .W_HILO   (W_HILO),
        .Write_HI (Write_HI),
        .Write_LO (Write_LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [2*W-1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        logic signed [W-1:0] sq, sr;
        case (op)
            2'b00: model = {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b};
            2'b01: model = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            2'b10: begin
                if (b == '0)
                    model = {a, {W{1'b1}}};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    model = {32'h0, 32'h8000_0000};
                else begin
                    sq = $signed(a) / $signed(b);
                    sr = $signed(a) % $signed(b);
                    model = {sr, sq};
                end
            end
            default: model = (b == '0) ? {a, {W{1'b1}}} : {a % b, a / b};
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst && W_HILO) begin
            if (exp_q.size() == 0)
                chk("spurious_whilo", {63'b0, W_HILO}, 64'd0);
            else
                chk("result", {Write_HI, Write_LO}, exp_q.pop_front());
        end
    end

    // Issue one op at a negedge; returns with n = cycles after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        md_op = op; SrcA = a; SrcB = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; SrcA = $urandom; SrcB = $urandom; md_op = 2'($urandom_range(0, 3));
        chk("busy_early", {63'b0, busy}, 64'd1);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp, input bit inj);
        int n;
        exp_q.push_back(exp);
        issue(op, a, b);
        n = 1;
        while (n < 60 && !W_HILO) begin
            if (inj && (n == 5 || n == 33)) begin
                start = 1'b1; SrcA = $urandom; SrcB = $urandom; md_op = 2'($urandom_range(0, 3));
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("latency", 64'(n - 1), 64'(W + 2));
        chk("busy_done", {63'b0, busy}, 64'd1);
        if (inj) begin
            start = 1'b1; SrcA = $urandom; SrcB = $urandom;
        end
        @(negedge clk);
        start = 1'b0;
        chk("whilo_width", {63'b0, W_HILO}, 64'd0);
        chk("busy_after", {63'b0, busy}, 64'd0);
        chk("hold", {Write_HI, Write_LO}, exp);
        last_exp = exp;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra, rb;
        logic [1:0]   rop;
        rst = 1'b1; start = 1'b0; md_op = 2'b00; SrcA = '0; SrcB = '0;
`ifdef MULDIV_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_whilo", {63'b0, W_HILO}, 64'd0);
        chk("rst_hilo", {Write_HI, Write_LO}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", {63'b0, busy}, 64'd0);

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0);
        run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
        run_op(2'b11, 32'h0000_0064, 32'h0000_0000, 64'h0000_0064_FFFF_FFFF, 1'b0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0);
        run_op(2'b10, 32'hFFFF_FFF0, 32'h0000_0000, 64'hFFFF_FFF0_FFFF_FFFF, 1'b0);
        run_op(2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 1'b0);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0);
        // Starts mid-run and in the write cycle must be ignored.
        run_op(2'b11, 32'd1000, 32'd7, {32'd6, 32'd142}, 1'b1);

        for (int i = 0; i < 8; i++) begin
            rop = 2'(i % 4);
            ra  = $urandom;
            rb  = (i > 3) ? 32'($urandom_range(1, 300)) : $urandom;
            run_op(rop, ra, rb, model(rop, ra, rb), 1'b0);
        end

        // Reset in the middle of CALC abandons the operation.
        issue(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (11) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", {63'b0, busy}, 64'd0);
        chk("midrst_whilo", {63'b0, W_HILO}, 64'd0);
        chk("midrst_hilo", {Write_HI, Write_LO}, 64'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("midrst_quiet", {63'b0, busy}, 64'd0);
        run_op(2'b00, 32'h0000_0007, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0);

        // Reset and start on the same edge: reset wins.
        @(negedge clk);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("rst_start_busy", {63'b0, busy}, 64'd0);
        run_op(2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 64'h0000_000F_0FFF_FFFF, 1'b0);

`ifdef MULDIV_ABORT_EN
        issue(2'b01, 32'h0000_0003, 32'h0000_0003);
        repeat (19) @(negedge clk);
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        chk("abort_busy", {63'b0, busy}, 64'd0);
        chk("abort_hold", {Write_HI, Write_LO}, last_exp);
        repeat (40) @(negedge clk);
        chk("abort_quiet", {63'b0, busy}, 64'd0);
        run_op(2'b01, 32'h0000_0003, 32'h0000_0003, 64'd9, 1'b0);
`endif

        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
